// File: rtl/color_pkg.sv
// Shared colour codes, controller states and RGB444 field positions used by the
// colour filter and by parcel_color_ctrl.
package color_pkg;

    typedef enum logic [2:0] {
        COL_NONE  = 3'd0,
        COL_RED   = 3'd1,
        COL_GREEN = 3'd2,
        COL_BLUE  = 3'd3
    } color_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DECIDE
    } ctrl_state_t;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // Codes 4..7 have no colour meaning downstream and collapse to "none".
    function automatic color_t sanitize_color(input logic [2:0] code);
        color_t c;
        case (code)
            3'd1:    c = COL_RED;
            3'd2:    c = COL_GREEN;
            3'd3:    c = COL_BLUE;
            default: c = COL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/parcel_color_ctrl_pixel_classifier.sv
// Combinational dominance test of one RGB444 pixel; at most one of the
// {red,green,blue} hit bits can be set.
module pixel_classifier
    import color_pkg::*;
#(
    parameter int MARGIN    = 2,
    parameter int MIN_LEVEL = 4
) (
    input  logic [11:0] i_pixel,
    input  logic        i_valid,
    output logic [2:0]  o_hit
);

    localparam logic [4:0] MARGIN_5 = 5'(MARGIN);
    localparam logic [4:0] LEVEL_5  = 5'(MIN_LEVEL);

    logic [4:0] w_r;
    logic [4:0] w_g;
    logic [4:0] w_b;

    // Widened to 5 bits so channel + MARGIN cannot wrap past 15.
    assign w_r = {1'b0, i_pixel[R_MSB:R_LSB]};
    assign w_g = {1'b0, i_pixel[G_MSB:G_LSB]};
    assign w_b = {1'b0, i_pixel[B_MSB:B_LSB]};

    assign o_hit[2] = i_valid && (w_r >= LEVEL_5) && (w_r > w_g + MARGIN_5) && (w_r > w_b + MARGIN_5);
    assign o_hit[1] = i_valid && (w_g >= LEVEL_5) && (w_g > w_r + MARGIN_5) && (w_g > w_b + MARGIN_5);
    assign o_hit[0] = i_valid && (w_b >= LEVEL_5) && (w_b > w_r + MARGIN_5) && (w_b > w_g + MARGIN_5);

endmodule

// File: rtl/parcel_color_ctrl.sv
// Frame-synchronous chooser of the parcel colour code: counts dominant pixels per
// frame, debounces the winner across frames and honours a frame-sampled override.
module parcel_color_ctrl
    import color_pkg::*;
#(
    parameter int CNT_W          = 19,
    parameter int MARGIN         = 2,
    parameter int MIN_LEVEL      = 4,
    parameter int MIN_PIXELS     = 1024,
    parameter int CONFIRM_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_in,
    input  logic        in_ready,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        cfg_override_en,
    input  logic [2:0]  cfg_color,
    output logic [2:0]  parcel_color,
    output logic        decision_valid,
    output logic        frame_abort
);

    localparam int                CONF_W   = $clog2(CONFIRM_FRAMES + 1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W:0]    MIN_PX   = (CNT_W + 1)'(MIN_PIXELS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    ctrl_state_t       r_state;
    ctrl_state_t       w_next_state;
    logic [CNT_W-1:0]  r_cnt [0:2];
    logic [2:0]        w_hit;
    color_t            w_winner;
    logic [CNT_W-1:0]  w_max;
    logic [CONF_W-1:0] w_confirm;
    color_t            r_parcel;
    color_t            r_candidate;
    logic [CONF_W-1:0] r_confirm;
    logic              r_latched;
    logic              r_decision_valid;
    logic              r_frame_abort;

    pixel_classifier #(
        .MARGIN   (MARGIN),
        .MIN_LEVEL(MIN_LEVEL)
    ) u_classifier (
        .i_pixel(pixel_in),
        .i_valid(in_ready),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (frame_start) w_next_state = frame_end ? ST_DECIDE : ST_ACCUM;
            ST_ACCUM:  if (frame_end) w_next_state = ST_DECIDE;
            ST_DECIDE: w_next_state = frame_start ? (frame_end ? ST_DECIDE : ST_ACCUM) : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Index 0/1/2 = red/green/blue; hit bits arrive as {red,green,blue}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (frame_start)
                    r_cnt[k] <= CNT_W'(w_hit[2-k]);
                else if (r_state == ST_ACCUM && w_hit[2-k] && r_cnt[k] != CNT_MAX)
                    r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    // Strict '>' keeps ties with the lower colour code.
    always_comb begin
        w_winner = COL_RED;
        w_max    = r_cnt[0];
        if (r_cnt[1] > w_max) begin
            w_winner = COL_GREEN;
            w_max    = r_cnt[1];
        end
        if (r_cnt[2] > w_max) begin
            w_winner = COL_BLUE;
            w_max    = r_cnt[2];
        end
        if ({1'b0, w_max} < MIN_PX) w_winner = COL_NONE;
    end

    always_comb begin
        w_confirm = CONF_W'(1);
        if (w_winner == r_candidate)
            w_confirm = (r_confirm == CONF_MAX) ? CONF_MAX : r_confirm + 1'b1;
    end

    // An override on a frame_start cycle takes precedence over a coincident decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parcel         <= COL_NONE;
            r_candidate      <= COL_NONE;
            r_confirm        <= '0;
            r_latched        <= 1'b0;
            r_decision_valid <= 1'b0;
            r_frame_abort    <= 1'b0;
        end else begin
            r_decision_valid <= (r_state == ST_DECIDE);
            r_frame_abort    <= (r_state == ST_ACCUM) && frame_start;
            if (frame_start && cfg_override_en) begin
                r_parcel    <= sanitize_color(cfg_color);
                r_latched   <= 1'b1;
                r_candidate <= COL_NONE;
                r_confirm   <= '0;
            end else begin
                if (frame_start) r_latched <= 1'b0;
                if (r_state == ST_DECIDE) begin
                    r_candidate <= w_winner;
                    r_confirm   <= w_confirm;
                    if (w_confirm == CONF_MAX && !r_latched) r_parcel <= w_winner;
                end else if (r_state == ST_ACCUM && frame_start) begin
                    r_confirm <= '0;
                end
            end
        end
    end

    assign parcel_color   = r_parcel;
    assign decision_valid = r_decision_valid;
    assign frame_abort    = r_frame_abort;

endmodule

// File: tb/tb_parcel_color_ctrl.sv
// Self-checking bench for parcel_color_ctrl: directed frame table, randomized
// frames against a frame-level reference model, and hand-written reset/IDLE cases.
module tb_parcel_color_ctrl;

    localparam int MIN_PX  = 4;
    localparam int CONFIRM = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pixel_in;
    logic        in_ready;
    logic        frame_start;
    logic        frame_end;
    logic        cfg_override_en;
    logic [2:0]  cfg_color;
    logic [2:0]  parcel_color;
    logic        decision_valid;
    logic        frame_abort;

    parcel_color_ctrl #(
        .CNT_W         (19),
        .MARGIN        (2),
        .MIN_LEVEL     (4),
        .MIN_PIXELS    (MIN_PX),
        .CONFIRM_FRAMES(CONFIRM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_in       (pixel_in),
        .in_ready       (in_ready),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .cfg_override_en(cfg_override_en),
        .cfg_color      (cfg_color),
        .parcel_color   (parcel_color),
        .decision_valid (decision_valid),
        .frame_abort    (frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pixA;
        int          nA;
        logic [11:0] pixB;
        int          nB;
        int          len;
        int          abortAt;
        logic        ovrEn;
        logic [2:0]  ovrCol;
        int          expColor;
    } frame_vec_t;

    frame_vec_t vecs[$];
    int passCount  = 0;
    int checkCount = 0;

    // Frame-level reference state: output colour, debounce candidate/count, override latch.
    int mColor, mCand, mConf;
    bit mLatched;
    int mCnt[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int classify(input logic [11:0] pix, input logic valid);
        int r, g, b;
        r = int'(pix[11:8]);
        g = int'(pix[7:4]);
        b = int'(pix[3:0]);
        if (!valid) return 0;
        if (r >= 4 && r > g + 2 && r > b + 2) return 1;
        if (g >= 4 && g > r + 2 && g > b + 2) return 2;
        if (b >= 4 && b > r + 2 && b > g + 2) return 3;
        return 0;
    endfunction

    function automatic logic [11:0] randomPixel();
        logic [3:0] hi, lo1, lo2;
        hi  = 4'($urandom_range(6, 15));
        lo1 = 4'($urandom_range(0, 7));
        lo2 = 4'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0:       return {hi, lo1, lo2};
            1:       return {lo1, hi, lo2};
            2:       return {lo1, lo2, hi};
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic modelReset();
        mColor = 0; mCand = 0; mConf = 0; mLatched = 0;
        for (int c = 0; c < 4; c++) mCnt[c] = 0;
    endtask

    task automatic modelFrameStart(input logic en, input logic [2:0] col);
        for (int c = 0; c < 4; c++) mCnt[c] = 0;
        if (en) begin
            mColor   = (col < 4) ? int'(col) : 0;
            mLatched = 1;
            mCand    = 0;
            mConf    = 0;
        end else begin
            mLatched = 0;
        end
    endtask

    task automatic modelDecide();
        int best = 1;
        if (mCnt[2] > mCnt[best]) best = 2;
        if (mCnt[3] > mCnt[best]) best = 3;
        if (mCnt[best] < MIN_PX) best = 0;
        if (best == mCand) begin
            mConf = (mConf + 1 > CONFIRM) ? CONFIRM : mConf + 1;
        end else begin
            mCand = best;
            mConf = 1;
        end
        if (mConf == CONFIRM && !mLatched) mColor = best;
    endtask

    task automatic addVec(input logic [11:0] pixA, input int nA, input logic [11:0] pixB, input int nB,
                          input int len, input int abortAt, input logic ovrEn, input logic [2:0] ovrCol,
                          input int expColor);
        frame_vec_t v;
        v.pixA = pixA; v.nA = nA; v.pixB = pixB; v.nB = nB;
        v.len = len; v.abortAt = abortAt; v.ovrEn = ovrEn; v.ovrCol = ovrCol;
        v.expColor = expColor;
        vecs.push_back(v);
    endtask

    // Drives one frame (optionally restarted at abortAt), then checks the decision.
    task automatic applyStimulus(input int len, input int abortAt, input logic [11:0] pixA, input int nA,
                                 input logic [11:0] pixB, input int nB, input bit randPix,
                                 input logic ovrEn, input logic [2:0] ovrCol,
                                 input bit useExp, input int expColor);
        int idx = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checkOutput("hold_color", parcel_color, mColor);
            checkOutput("hold_valid", decision_valid, 0);
            checkOutput("hold_abort", frame_abort, (abortAt >= 0 && i == abortAt + 1) ? 1 : 0);
            frame_start     = (i == 0 || i == abortAt);
            frame_end       = (i == len - 1);
            cfg_override_en = ovrEn;
            cfg_color       = ovrCol;
            if (frame_start) begin
                idx = 0;
                modelFrameStart(ovrEn, ovrCol);
                if (i != 0) mConf = 0;
            end
            if (randPix) begin
                in_ready = ($urandom_range(0, 4) != 0);
                pixel_in = randomPixel();
            end else begin
                in_ready = 1'b1;
                pixel_in = (idx < nA) ? pixA : (idx < nA + nB) ? pixB : 12'h000;
            end
            mCnt[classify(pixel_in, in_ready)]++;
            idx++;
        end
        @(negedge clk);
        checkOutput("decide_hold_color", parcel_color, mColor);
        checkOutput("decide_hold_valid", decision_valid, 0);
        frame_start     = 1'b0;
        frame_end       = 1'b0;
        in_ready        = 1'b0;
        cfg_override_en = 1'b0;
        modelDecide();
        @(negedge clk);
        checkOutput("decision_valid", decision_valid, 1);
        checkOutput("abort_after_decide", frame_abort, 0);
        checkOutput("parcel_color", parcel_color, useExp ? expColor : mColor);
    endtask

    initial begin
        rst_n = 1'b0; pixel_in = '0; in_ready = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        cfg_override_en = 1'b0; cfg_color = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_color", parcel_color, 0);
        checkOutput("reset_valid", decision_valid, 0);
        checkOutput("reset_abort", frame_abort, 0);
        rst_n = 1'b1;

        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 0);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'h1F1, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'h1F1, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 2);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 2);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'h0F0,  5, 12'h00F, 5, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'h0F0,  5, 12'h00F, 5, 16, -1, 1'b0, 3'd0, 2);
        addVec(12'h00F,  3, 12'h000, 0, 16, -1, 1'b0, 3'd0, 2);
        addVec(12'h00F,  3, 12'h000, 0, 16, -1, 1'b0, 3'd0, 0);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 0);
        addVec(12'hF11, 10, 12'h000, 0, 24,  8, 1'b0, 3'd0, 0);
        addVec(12'h00F, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 0);
        addVec(12'h00F, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 3);
        addVec(12'h1F1, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 3);
        addVec(12'h1F1, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 2);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b1, 3'd3, 3);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b1, 3'd3, 3);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b0, 3'd0, 1);
        addVec(12'hF11, 10, 12'h000, 0, 16, -1, 1'b1, 3'd5, 0);
        addVec(12'hF11,  1, 12'h000, 0,  1, -1, 1'b0, 3'd0, 0);

        foreach (vecs[v])
            applyStimulus(vecs[v].len, vecs[v].abortAt, vecs[v].pixA, vecs[v].nA, vecs[v].pixB,
                          vecs[v].nB, 1'b0, vecs[v].ovrEn, vecs[v].ovrCol, 1'b1, vecs[v].expColor);

        for (int f = 0; f < 40; f++) begin
            int gap, len, abortAt;
            logic ovrEn;
            logic [2:0] ovrCol;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkOutput("gap_color", parcel_color, mColor);
                checkOutput("gap_valid", decision_valid, 0);
                frame_start     = 1'b0;
                frame_end       = ($urandom_range(0, 3) == 0);
                in_ready        = 1'($urandom);
                pixel_in        = 12'($urandom);
                cfg_override_en = 1'($urandom);
                cfg_color       = 3'($urandom);
            end
            len     = $urandom_range(1, 20);
            abortAt = (len >= 3 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 2) : -1;
            ovrEn   = ($urandom_range(0, 5) == 0);
            ovrCol  = 3'($urandom_range(0, 7));
            applyStimulus(len, abortAt, 12'h000, 0, 12'h000, 0, 1'b1, ovrEn, ovrCol, 1'b0, 0);
        end

        applyStimulus(16, -1, 12'hF11, 10, 12'h000, 0, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        applyStimulus(16, -1, 12'hF11, 10, 12'h000, 0, 1'b0, 1'b0, 3'd0, 1'b1, 1);

        // Asynchronous reset in the middle of an accumulating frame.
        @(negedge clk);
        frame_start = 1'b1; in_ready = 1'b1; pixel_in = 12'hF11;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_color", parcel_color, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_color", parcel_color, 0);
        checkOutput("async_reset_valid", decision_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        frame_end = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            frame_end = 1'b0;
            checkOutput("idle_frame_end_ignored", decision_valid, 0);
        end
        in_ready = 1'b0;
        applyStimulus(16, -1, 12'hF11, 10, 12'h000, 0, 1'b0, 1'b0, 3'd0, 1'b1, 0);
        applyStimulus(16, -1, 12'hF11, 10, 12'h000, 0, 1'b0, 1'b0, 3'd0, 1'b1, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
